conv_frame_tx: RTL and testbench
================================

// Module: conv_frame_tx
// PURPOSE
//  Frame transmitter feeding the convolution engine's AXI-stream pixel ingress.
//  Takes an unframed raw pixel stream and emits it as framed AXI-stream beats:
//  tuser marks SOF (first pixel of the frame) and tlast marks EOL (last pixel of each line).
//  Framing comes from runtime cfg_width_i x cfg_height_i. Sits between a pixel source/DMA and conv_cntrl.
// PARAMETERS
//  PIXEL_W   conv_pkg::PIXEL_W  pixel data width
//  DIM_W     11                 width of dimension fields/counters (max 2^DIM_W-1 px per line/lines per frame)
//  FCNT_W    16                 completed-frame counter width
// PORTS
//  clk           in   1        clock
//  rst           in   1        synchronous reset, active-high
//  start_i       in   1        frame start request (1-cycle pulse)
//  cfg_width_i   in   DIM_W    pixels per line, sampled on accepted start
//  cfg_height_i  in   DIM_W    lines per frame, sampled on accepted start
//  busy_o        out  1        1 in RUN or DRAIN
//  done_o        out  1        1-cycle pulse on frame completion
//  cfg_err_o     out  1        1-cycle pulse: start rejected (zero dimension)
//  frame_cnt_o   out  FCNT_W   count of completed frames
//  s_tvalid_i    in   1        raw pixel valid
//  s_tdata_i     in   PIXEL_W  raw pixel
//  s_tready_o    out  1        raw pixel accept
//  m_tvalid_o    out  1        framed beat valid
//  m_tdata_o     out  PIXEL_W  framed pixel
//  m_tuser_o     out  1        SOF
//  m_tlast_o     out  1        EOL
//  m_tready_i    in   1        downstream accept
// BEHAVIOUR
//  Reset (sync, active-high): state IDLE; counters 0; skid buffer empty.
//   All outputs 0, frame_cnt_o = 0. Reset mid-frame abandons the frame:
//   buffered beats are discarded, no done_o, and frame_cnt_o is cleared.
//  FSM IDLE -> RUN -> DRAIN -> IDLE:
//   IDLE:  start_i with width!=0 & height!=0 -> latch cfg, col=row=0, RUN.
//          start_i with either dimension 0 -> cfg_err_o=1 next cycle, stay IDLE.
//   RUN:   input handshake (s_tvalid_i & s_tready_o) consumes one pixel.
//          col++; at col==W-1, col=0 and row++. Accepting pixel (W-1,H-1) -> DRAIN.
//   DRAIN: s_tready_o=0. When the skid buffer is empty -> IDLE.
//          done_o=1 and frame_cnt_o++ in the first IDLE cycle.
//   start_i outside IDLE is ignored (no error, no effect).
//  Tagging: tuser = (col==0 & row==0); tlast = (col==W-1).
//   Computed from pre-increment counters.
//   W==1: every beat has tlast=1; the first beat has tuser=tlast=1.
//  Output: 2-entry skid buffer {data,tuser,tlast}, all outputs registered.
//   s_tready_o = (state==RUN) & (entries < 2), registered (no comb path from m_tready_i).
//   Latency: input handshake at cycle N -> m_tvalid_o at N+1 if buffer empty.
//   Full throughput (1 beat/cycle) with m_tready_i held high.
//   AXI rule: once m_tvalid_o=1, data/tuser/tlast hold stable until m_tready_i.
//   Beat order is preserved. Simultaneous push and pop keeps the count unchanged.
//  Widths: counters DIM_W bits, compare against latched cfg-1. frame_cnt_o wraps 2^FCNT_W-1 -> 0.
//  Downstream requires gap-free streams. Bubbles arise only from s_tvalid_i gaps or m_tready_i back-pressure.
// TESTING
//  T1: W=4,H=3, source always valid, m_tready_i=1 -> 12 beats in order.
//      tuser on beat 0 only; tlast on beats 3,7,11.
//      done_o one cycle after DRAIN empties; frame_cnt_o=1.
//  T2: W=4,H=2, m_tready_i toggling 1010.. -> no beat lost or duplicated.
//      Held beats are stable while m_tvalid_o=1 & m_tready_i=0.
//      s_tready_o drops when 2 entries are held.
//  T3: W=1,H=3 -> 3 beats: tuser/tlast = 11, 01, 01.
//  T4: start_i with W=0,H=5 -> cfg_err_o pulse, busy_o stays 0, no beats.
//      start_i during RUN is ignored and the cfg is unchanged.
//  T5: rst asserted after 5 of 12 beats -> all outputs 0 next cycle.
//      A new start then yields a correct frame from tuser and frame_cnt_o=1.
//  T6: 3 back-to-back frames of W=8,H=8 (start_i on each done_o) -> frame_cnt_o 1,2,3.
//      Force frame_cnt to 2^FCNT_W-1; one more frame -> 0.

Source files
------------

// File: rtl/conv_frame_tx.sv
// conv_frame_tx: frames a raw pixel stream into AXI-stream beats (tuser=SOF, tlast=EOL)
//   clk, rst                     clock, synchronous active-high reset
//   start_i, cfg_width_i/height_i  frame request and dimensions (sampled on accepted start)
//   busy_o, done_o, cfg_err_o, frame_cnt_o  status
//   s_tvalid_i/s_tdata_i/s_tready_o        raw pixel ingress
//   m_tvalid_o/m_tdata_o/m_tuser_o/m_tlast_o/m_tready_i  framed egress
module conv_frame_tx #(
  parameter int PIXEL_W = 8,
  parameter int DIM_W   = 11,
  parameter int FCNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [DIM_W-1:0]   cfg_width_i,
  input  logic [DIM_W-1:0]   cfg_height_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               cfg_err_o,
  output logic [FCNT_W-1:0]  frame_cnt_o,
  input  logic               s_tvalid_i,
  input  logic [PIXEL_W-1:0] s_tdata_i,
  output logic               s_tready_o,
  output logic               m_tvalid_o,
  output logic [PIXEL_W-1:0] m_tdata_o,
  output logic               m_tuser_o,
  output logic               m_tlast_o,
  input  logic               m_tready_i
);
  localparam int BW = PIXEL_W + 2;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d, wm1_q, wm1_d, hm1_q, hm1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [BW-1:0] head_q, head_d, tail_q, tail_d, beat;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic s_rdy_q, s_rdy_d, done_q, done_d, err_q, err_d;
  logic push, pop, last_col;
  always_comb begin
    push = s_tvalid_i & s_rdy_q;
    pop = m_tready_i & (cnt_q != 2'd0);
    last_col = col_q == wm1_q;
    beat = {s_tdata_i, col_q == '0 && row_q == '0, last_col};
    state_d = state_q;
    col_d = col_q;
    row_d = row_q;
    wm1_d = wm1_q;
    hm1_d = hm1_q;
    fcnt_d = fcnt_q;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (|cfg_width_i && |cfg_height_i) begin
          state_d = RUN;
          wm1_d = cfg_width_i - DIM_W'(1);
          hm1_d = cfg_height_i - DIM_W'(1);
          col_d = '0;
          row_d = '0;
        end else err_d = 1'b1;
      end
      RUN: if (push) begin
        col_d = last_col ? '0 : col_q + DIM_W'(1);
        row_d = last_col ? row_q + DIM_W'(1) : row_q;
        if (last_col && row_q == hm1_q) state_d = DRAIN;
      end
      DRAIN: if (cnt_q == 2'd0) begin
        state_d = IDLE;
        done_d = 1'b1;
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    cnt_d = cnt_q + 2'(push) - 2'(pop);
    // head is the presented beat; tail only matters when two beats are held
    head_d = pop ? (cnt_q == 2'd2 ? tail_q : beat) : (cnt_q == 2'd0 ? beat : head_q);
    tail_d = push ? beat : tail_q;
    // ready is registered from next-state occupancy, so no path from m_tready_i
    s_rdy_d = state_d == RUN && cnt_d < 2'd2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      col_q <= '0;
      row_q <= '0;
      wm1_q <= '0;
      hm1_q <= '0;
      cnt_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fcnt_q <= '0;
      s_rdy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q <= col_d;
      row_q <= row_d;
      wm1_q <= wm1_d;
      hm1_q <= hm1_d;
      cnt_q <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fcnt_q <= fcnt_d;
      s_rdy_q <= s_rdy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign cfg_err_o = err_q;
  assign frame_cnt_o = fcnt_q;
  assign s_tready_o = s_rdy_q;
  assign m_tvalid_o = cnt_q != 2'd0;
  assign m_tdata_o = head_q[BW-1:2];
  assign m_tuser_o = head_q[1];
  assign m_tlast_o = head_q[0];
endmodule

// File: tb/tb_conv_frame_tx.sv
// tb_conv_frame_tx: scoreboard bench for conv_frame_tx
module tb_conv_frame_tx;
  localparam int PW = 8, DW = 11, FW = 3, BW = PW + 2;
  logic clk = 1'b0, rst = 1'b1, start_i = 1'b0;
  logic [DW-1:0] cfg_width_i = '0, cfg_height_i = '0;
  logic busy_o, done_o, cfg_err_o, s_tready_o, m_tvalid_o, m_tuser_o, m_tlast_o;
  logic [FW-1:0] frame_cnt_o;
  logic s_tvalid_i = 1'b1, m_tready_i = 1'b1;
  logic [PW-1:0] s_tdata_i, m_tdata_o;
  logic [BW-1:0] q[$];
  logic [BW-1:0] held_beat, exp_beat;
  int n_chk = 0, n_pass = 0, cyc = 0, n_pop = 0, gaps = 0, stalls = 0, last_pop = -10;
  int src_idx = 0, src_base = 0, cur_total = 0, last_gaps = 0, last_stalls = 0;
  bit rdy_toggle = 0, src_acc = 0, held = 0;
  always #5 clk = ~clk;
  assign s_tdata_i = PW'(src_base + src_idx);
  conv_frame_tx #(.PIXEL_W(PW), .DIM_W(DW), .FCNT_W(FW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_width_i(cfg_width_i),
    .cfg_height_i(cfg_height_i), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .frame_cnt_o(frame_cnt_o), .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i),
    .s_tready_o(s_tready_o), .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o),
    .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o), .m_tready_i(m_tready_i)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  always @(posedge clk) begin
    cyc++;
    #1;
    if (!busy_o) src_idx = 0;
    else if (src_acc) src_idx++;
    m_tready_i = rdy_toggle ? !m_tready_i : 1'b1;
  end
  always @(negedge clk) begin
    src_acc = s_tvalid_i & s_tready_o;
    if (busy_o && !s_tready_o && src_idx < cur_total) stalls++;
    if (held) chk("hold", {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o}, {1'b1, held_beat});
    held = m_tvalid_o & !m_tready_i & !rst;
    held_beat = {m_tdata_o, m_tuser_o, m_tlast_o};
    if (rst) q.delete();
    else if (m_tvalid_o & m_tready_i) begin
      exp_beat = q.size() != 0 ? q.pop_front() : 'x;
      chk("beat", {m_tdata_o, m_tuser_o, m_tlast_o}, exp_beat);
      n_pop++;
      if (cyc != last_pop + 1) gaps++;
      last_pop = cyc;
    end
  end
  task automatic pulse_start(input int w, input int h);
    cfg_width_i = DW'(w);
    cfg_height_i = DW'(h);
    start_i = 1'b1;
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask
  task automatic push_frame(input int w, input int h, input int base);
    src_base = base;
    cur_total = w * h;
    for (int p = 0; p < w * h; p++) q.push_back({PW'(base + p), p == 0, (p % w) == w - 1});
  endtask
  task automatic run_frame(input int w, input int h, input int base, input int exp_cnt, input bit inj);
    int g0, s0;
    bit got;
    got = 0;
    push_frame(w, h, base);
    g0 = gaps;
    s0 = stalls;
    pulse_start(w, h);
    chk("busy_run", busy_o, 1);
    if (inj) begin
      repeat (4) @(negedge clk);
      pulse_start(2, 2);
    end
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      got = done_o;
    end
    chk("done", got, 1);
    chk("idle_at_done", {busy_o, m_tvalid_o}, 0);
    chk("frame_cnt", frame_cnt_o, exp_cnt);
    chk("q_drained", q.size(), 0);
    last_gaps = gaps - g0;
    last_stalls = stalls - s0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {m_tvalid_o, m_tdata_o, m_tuser_o, m_tlast_o, s_tready_o, busy_o, done_o,
              cfg_err_o, frame_cnt_o}, 0);
  endtask
  initial begin
    int n0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset_state");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_frame(4, 3, 16, 1, 0);
    chk("t1_gapfree", last_gaps, 1);
    chk("t1_no_stall", last_stalls, 0);
    rdy_toggle = 1;
    run_frame(4, 2, 64, 2, 0);
    chk("t2_stall", last_stalls != 0, 1);
    rdy_toggle = 0;
    run_frame(1, 3, 200, 3, 0);
    n0 = n_pop;
    pulse_start(0, 5);
    @(negedge clk);
    chk("t4_err", {cfg_err_o, busy_o, m_tvalid_o}, 3'b100);
    @(negedge clk);
    chk("t4_err_pulse", {cfg_err_o, busy_o}, 0);
    chk("t4_no_beats", n_pop - n0, 0);
    run_frame(4, 3, 32, 4, 1);
    push_frame(4, 3, 100);
    n0 = n_pop;
    pulse_start(4, 3);
    for (int i = 0; i < 200 && n_pop - n0 < 5; i++) @(negedge clk);
    chk("t5_progress", n_pop - n0 >= 5, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_zero("t5_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    run_frame(4, 3, 50, 1, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int f = 1; f <= 3; f++) run_frame(8, 8, f * 7, f, 0);
    for (int f = 4; f <= 7; f++) run_frame(2, 2, f, f, 0);
    run_frame(2, 2, 9, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
